// File: rtl/fmc_adc_ext_trig_pkg.sv
// Shared types, default widths and helpers for the FMC-ADC external trigger conditioner.
package fmc_adc_ext_trig_pkg;

   typedef enum logic {
      IDLE,
      DELAY
   } trig_state_t;

   localparam int unsigned c_DLY_WIDTH  = 32;
   localparam int unsigned c_FILT_WIDTH = 4;
   localparam int unsigned c_CNT_WIDTH  = 16;

   // Saturating increment of a counter held in the low 'width' bits of val.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/fmc_adc_trig_glitch_filt.sv
// Glitch filter: output follows the input only after it has differed for len_i+1 cycles.
module fmc_adc_trig_glitch_filt
   import fmc_adc_ext_trig_pkg::*;
#(
   parameter int unsigned g_FILT_WIDTH = c_FILT_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    d_i,
   input  logic [g_FILT_WIDTH-1:0] len_i,
   output logic                    q_o
);

   logic [g_FILT_WIDTH-1:0] run;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         run <= '0;
         q_o <= 1'b0;
      end else if (d_i == q_o) begin
         run <= '0;
      end else if (run == len_i) begin
         q_o <= d_i;
         run <= '0;
      end else begin
         run <= run + 1'b1;
      end
   end

endmodule

// File: rtl/fmc_adc_ext_trig_cond.sv
// External trigger conditioner: sync, optional glitch filter, edge select, delay, statistics.
// Define FMC_ADC_EXT_TRIG_FILTER_EN to include the glitch filter.
module fmc_adc_ext_trig_cond
   import fmc_adc_ext_trig_pkg::*;
#(
   parameter int unsigned g_DLY_WIDTH  = c_DLY_WIDTH,
   parameter int unsigned g_FILT_WIDTH = c_FILT_WIDTH,
   parameter int unsigned g_CNT_WIDTH  = c_CNT_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    trig_i,
   input  logic                    en_i,
   input  logic                    pol_i,
   input  logic [g_FILT_WIDTH-1:0] filt_len_i,
   input  logic [g_DLY_WIDTH-1:0]  dly_i,
   input  logic                    clr_i,
   output logic                    trig_p_o,
   output logic                    busy_o,
   output logic [g_CNT_WIDTH-1:0]  trig_cnt_o,
   output logic [g_CNT_WIDTH-1:0]  miss_cnt_o
);

   logic [1:0]             sync;
   logic                   lvl;
   logic                   lvl_d;
   logic                   edge_p;
   logic                   fire;
   logic                   miss;
   trig_state_t            state;
   logic [g_DLY_WIDTH-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync <= '0;
      else          sync <= {sync[0], trig_i};
   end

`ifdef FMC_ADC_EXT_TRIG_FILTER_EN
   fmc_adc_trig_glitch_filt #(
      .g_FILT_WIDTH (g_FILT_WIDTH)
   ) u_glitch_filt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (sync[1]),
      .len_i   (filt_len_i),
      .q_o     (lvl)
   );
`else
   logic unused_filt_len;
   assign unused_filt_len = ^filt_len_i;
   assign lvl             = sync[1];
`endif

   // Level tracking runs regardless of en_i, so enabling onto an active level is not an edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lvl_d  <= 1'b0;
         edge_p <= 1'b0;
      end else begin
         lvl_d  <= lvl;
         edge_p <= en_i & (pol_i ? (lvl_d & ~lvl) : (lvl & ~lvl_d));
      end
   end

   always_comb begin
      fire = 1'b0;
      miss = 1'b0;
      if (en_i) begin
         unique case (state)
            IDLE:  fire = edge_p && (dly_i == '0);
            DELAY: begin
               fire = (cnt == g_DLY_WIDTH'(1));
               miss = edge_p;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         cnt        <= '0;
         trig_p_o   <= 1'b0;
         trig_cnt_o <= '0;
         miss_cnt_o <= '0;
      end else begin
         trig_p_o <= fire;
         if (!en_i) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: if (edge_p && (dly_i != '0)) begin
                  cnt   <= dly_i;
                  state <= DELAY;
               end
               DELAY: if (cnt == g_DLY_WIDTH'(1)) state <= IDLE;
                      else                        cnt   <= cnt - 1'b1;
            endcase
         end
         if (clr_i) begin
            trig_cnt_o <= '0;
            miss_cnt_o <= '0;
         end else begin
            if (fire) trig_cnt_o <= g_CNT_WIDTH'(sat_inc(32'(trig_cnt_o), g_CNT_WIDTH));
            if (miss) miss_cnt_o <= g_CNT_WIDTH'(sat_inc(32'(miss_cnt_o), g_CNT_WIDTH));
         end
      end
   end

   assign busy_o = (state == DELAY);

endmodule

// File: tb/tb_fmc_adc_ext_trig_cond.sv
// Scoreboard bench for fmc_adc_ext_trig_cond; follows FMC_ADC_EXT_TRIG_FILTER_EN like the DUT.
module tb_fmc_adc_ext_trig_cond;

   localparam int unsigned CW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned FW = 4;
   localparam int MAXC = (1 << CW) - 1;
`ifdef FMC_ADC_EXT_TRIG_FILTER_EN
   localparam bit FILT = 1'b1;
   localparam int LAT  = 4;
`else
   localparam bit FILT = 1'b0;
   localparam int LAT  = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trig = 1'b0;
   logic          en = 1'b0;
   logic          pol = 1'b0;
   logic          clr = 1'b0;
   logic [FW-1:0] flen = '0;
   logic [DW-1:0] dly = '0;
   logic          trig_p;
   logic          busy;
   logic [CW-1:0] trig_cnt;
   logic [CW-1:0] miss_cnt;

   always #4 clk = ~clk;

   fmc_adc_ext_trig_cond #(
      .g_DLY_WIDTH  (DW),
      .g_FILT_WIDTH (FW),
      .g_CNT_WIDTH  (CW)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .trig_i     (trig),
      .en_i       (en),
      .pol_i      (pol),
      .filt_len_i (flen),
      .dly_i      (dly),
      .clr_i      (clr),
      .trig_p_o   (trig_p),
      .busy_o     (busy),
      .trig_cnt_o (trig_cnt),
      .miss_cnt_o (miss_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: level transitions become edge decisions a fixed number of
   // cycles after the deciding sample; a pending trigger fires at an absolute cycle.
   typedef struct { int c; bit rising; } tr_t;
   typedef struct { int c; int cnt; }    exp_t;
   tr_t  tr_q[$];
   exp_t exp_q[$];
   tr_t  t;
   int   cyc = 0;
   bit   m_lvl, m_edge, m_ed, m_busy, m_fired;
   int   m_run, m_fire_at, m_tcnt, m_miss;

   function automatic int sat(input int v);
      return (v >= MAXC) ? MAXC : v + 1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         tr_q.delete();
         m_lvl = 0; m_run = 0; m_edge = 0; m_busy = 0; m_tcnt = 0; m_miss = 0;
      end else begin
         m_ed = m_edge;
         m_edge = 0;
         m_fired = 0;
         if (!en) m_busy = 0;
         else if (m_busy) begin
            if (m_ed) m_miss = sat(m_miss);
            if (cyc == m_fire_at) begin m_busy = 0; m_fired = 1; end
         end else if (m_ed) begin
            if (dly == 0) m_fired = 1;
            else begin m_busy = 1; m_fire_at = cyc + int'(dly); end
         end
         if (m_fired) m_tcnt = sat(m_tcnt);
         if (clr) begin m_tcnt = 0; m_miss = 0; end
         if (m_fired) exp_q.push_back('{cyc, m_tcnt});
         while (tr_q.size() > 0 && tr_q[0].c == cyc) begin
            t = tr_q.pop_front();
            if (en && (t.rising != pol)) m_edge = 1;
         end
         if (trig != m_lvl) begin
            m_run++;
            if (!FILT || m_run > int'(flen)) begin
               m_lvl = trig;
               m_run = 0;
               tr_q.push_back('{cyc + (FILT ? 3 : 2), trig});
            end
         end else m_run = 0;
      end
   end

   // Monitor: compares DUT outputs against the model away from the active edge.
   always @(negedge clk) begin
      bit exp_now;
      exp_now = (exp_q.size() > 0 && exp_q[0].c == cyc);
      check("trig_p", trig_p, exp_now);
      if (exp_now) begin
         check("pulse_trig_cnt", trig_cnt, exp_q[0].cnt);
         void'(exp_q.pop_front());
      end
      check("busy", busy, m_busy);
      check("trig_cnt", trig_cnt, m_tcnt);
      check("miss_cnt", miss_cnt, m_miss);
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse_clr();
      clr = 1'b1; wait_cyc(1); clr = 1'b0; wait_cyc(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int p_off, busy_n;
      en = 1; pol = 0; flen = 4'd3; dly = '0;
      wait_cyc(3);
      check("rst_trig_p", trig_p, 0);
      check("rst_busy", busy, 0);
      check("rst_trig_cnt", trig_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      rst_n = 1; wait_cyc(6);

      // Glitches then a long pulse
      trig = 1; wait_cyc(1); trig = 0; wait_cyc(3);
      trig = 1; wait_cyc(2); trig = 0; wait_cyc(4);
      trig = 1; p_off = -1;
      for (int j = 0; j < 13; j++) begin wait_cyc(1); if (trig_p && p_off < 0) p_off = j; end
      trig = 0; wait_cyc(12);
      check("glitch_latency", p_off, FILT ? 7 : 3);
      check("glitch_trig_cnt", trig_cnt, FILT ? 1 : 3);

      // Delay 3
      flen = '0; dly = 16'd3; pulse_clr();
      trig = 1; p_off = -1; busy_n = 0;
      for (int j = 0; j < 15; j++) begin
         wait_cyc(1);
         if (trig_p && p_off < 0) p_off = j;
         if (busy) busy_n++;
      end
      trig = 0; wait_cyc(8);
      check("dly_latency", p_off, LAT + 3);
      check("dly_busy_cycles", busy_n, 3);

      // Miss counting
      dly = 16'd100; pulse_clr();
      repeat (3) begin trig = 1; wait_cyc(4); trig = 0; wait_cyc(16); end
      wait_cyc(70);
      check("miss_miss_cnt", miss_cnt, 2);
      check("miss_trig_cnt", trig_cnt, 1);

      // Falling-edge polarity
      dly = '0; pol = 1; pulse_clr(); wait_cyc(3);
      trig = 1; wait_cyc(10);
      check("pol_rise_ignored", trig_cnt, 0);
      trig = 0; wait_cyc(10);
      check("pol_fall_fires", trig_cnt, 1);
      pol = 0; wait_cyc(3);

      // Abort by en_i mid-delay
      dly = 16'd50; pulse_clr();
      trig = 1; wait_cyc(LAT + 5);
      check("abort_busy_before", busy, 1);
      en = 0; wait_cyc(1);
      check("abort_busy_after", busy, 0);
      trig = 0; wait_cyc(60);
      check("abort_trig_cnt", trig_cnt, 0);
      check("abort_miss_cnt", miss_cnt, 0);
      trig = 1; wait_cyc(10);
      en = 1; wait_cyc(20);
      check("en_rise_active_level", trig_cnt, 0);
      trig = 0; wait_cyc(10);

      // Trigger counter saturation, then clear on a firing cycle
      dly = '0;
      repeat (MAXC + 2) begin trig = 1; wait_cyc(2); trig = 0; wait_cyc(2); end
      wait_cyc(8);
      check("sat_trig_cnt", trig_cnt, MAXC);
      trig = 1; wait_cyc(LAT);
      clr = 1; wait_cyc(1); clr = 0;
      check("clr_on_fire_pulse", trig_p, 1);
      trig = 0; wait_cyc(8);
      check("clr_on_fire_cnt", trig_cnt, 0);

      // Miss counter saturation
      dly = 16'd1500;
      repeat (MAXC + 5) begin trig = 1; wait_cyc(2); trig = 0; wait_cyc(2); end
      wait_cyc(500);
      check("sat_miss_cnt", miss_cnt, MAXC);
      check("sat_miss_trig_cnt", trig_cnt, 1);

      // Reset mid-delay
      dly = 16'd30;
      trig = 1; wait_cyc(LAT + 3); trig = 0; wait_cyc(2);
      check("rstmid_busy_before", busy, 1);
      rst_n = 0; #1;
      check("rstmid_trig_p", trig_p, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_trig_cnt", trig_cnt, 0);
      check("rstmid_miss_cnt", miss_cnt, 0);
      wait_cyc(3); rst_n = 1; wait_cyc(50);

      // Randomised traffic
      flen = FILT ? FW'($urandom_range(0, 3)) : '0;
      wait_cyc(10);
      for (int i = 0; i < 600; i++) begin
         trig = ~trig;
         en   = ($urandom_range(0, 19) != 0);
         dly  = DW'($urandom_range(0, 8));
         clr  = ($urandom_range(0, 30) == 0);
         if ($urandom_range(0, 40) == 0) pol = ~pol;
         wait_cyc($urandom_range(1, 6));
      end
      en = 1; clr = 0;
      wait_cyc(30);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
